// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module   : serial_add_ctrl_if
// Purpose  : Request/result bundle between a requester and serial_add_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder; one full-adder cell swept LSB first over WIDTH edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);

    localparam int                 CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_bit;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_accept;

    // Full adder built from two half adders
    assign w_ha1_s      = r_a[0] ^ r_b[0];
    assign w_ha1_c      = r_a[0] & r_b[0];
    assign w_bit        = w_ha1_s ^ r_carry;
    assign w_carry_next = w_ha1_c | (w_ha1_s & r_carry);

    assign w_last   = (r_cnt == LAST_BIT);
    assign w_accept = (r_state == IDLE) && bus.start;

    generate
        if (WIDTH == 1) begin : g_res_single
            assign w_res_next = w_bit;
        end else begin : g_res_multi
            assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_next;
            r_carry <= w_carry_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Final bit is folded into the published result on the same edge
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_carry_next;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

`default_nettype wire
